// File: rtl/mips_mem_loader.sv
// Preload-and-run controller for the MIPS core: streams segment headers and payload into the
// memory write ports, then runs the CPU until halt or timeout. Optional trailer checksum: CHECKSUM_EN.
module mips_mem_loader #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned NUM_MEMS = 3,
    parameter int unsigned CNT_W    = 16
) (
    input  logic                clk_CPU,
    input  logic                rst_CPU,
    input  logic                start,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [DATA_W-1:0]   in_data,
    output logic [NUM_MEMS-1:0] wr_en,
    output logic [ADDR_W-1:0]   wr_addr,
    output logic [DATA_W-1:0]   wr_data,
    output logic                cpu_run,
    input  logic                cpu_halt,
    output logic [CNT_W-1:0]    cycle_cnt,
    output logic                done,
    output logic                error,
    output logic [1:0]          err_code
);

    localparam int unsigned SEG_W = (NUM_MEMS > 1) ? $clog2(NUM_MEMS) : 1;
    localparam int unsigned LEN_W = ADDR_W + 1;
    localparam logic [SEG_W-1:0]  LAST_SEG = SEG_W'(NUM_MEMS - 1);
    localparam logic [DATA_W-1:0] MAX_LEN  = DATA_W'(2 ** ADDR_W);
    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
    localparam logic [1:0] ERR_LEN = 2'd1;
    localparam logic [1:0] ERR_TMO = 2'd2;

`ifdef CHECKSUM_EN
    localparam logic [1:0] ERR_SUM = 2'd3;
    typedef enum logic [2:0] {
        S_IDLE, S_HDR, S_DATA, S_CHK, S_RUN, S_DONE, S_ERR
    } state_t;
    logic [DATA_W-1:0] sum_q, sum_d;
`else
    typedef enum logic [2:0] {
        S_IDLE, S_HDR, S_DATA, S_RUN, S_DONE, S_ERR
    } state_t;
`endif

    state_t              state_q, state_d;
    logic [SEG_W-1:0]    seg_q, seg_d;
    logic [LEN_W-1:0]    rem_q, rem_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                in_ready_q, in_ready_d;
    logic [NUM_MEMS-1:0] wr_en_q, wr_en_d;
    logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0]   wr_data_q, wr_data_d;
    logic                cpu_run_q, cpu_run_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                done_q, done_d;
    logic                error_q, error_d;
    logic [1:0]          err_code_q, err_code_d;
    logic                fire;
    logic                seg_end;

    assign fire = in_valid & in_ready_q;

    // Next-state and registered-output logic
    always_comb begin
        state_d    = state_q;
        seg_d      = seg_q;
        rem_d      = rem_q;
        addr_d     = addr_q;
        wr_en_d    = '0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        cnt_d      = cnt_q;
        done_d     = done_q;
        error_d    = error_q;
        err_code_d = err_code_q;
        seg_end    = 1'b0;
`ifdef CHECKSUM_EN
        sum_d      = sum_q;
`endif
        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    state_d    = S_HDR;
                    seg_d      = '0;
                    cnt_d      = '0;
                    done_d     = 1'b0;
                    error_d    = 1'b0;
                    err_code_d = '0;
                end
            end
            S_HDR: begin
`ifdef CHECKSUM_EN
                sum_d = '0;
`endif
                if (fire) begin
                    if (in_data == '0) begin
`ifdef CHECKSUM_EN
                        state_d = S_CHK;
`else
                        seg_end = 1'b1;
`endif
                    end else if (in_data > MAX_LEN) begin
                        state_d    = S_ERR;
                        error_d    = 1'b1;
                        err_code_d = ERR_LEN;
                    end else begin
                        state_d = S_DATA;
                        rem_d   = LEN_W'(in_data);
                        addr_d  = '0;
                    end
                end
            end
            S_DATA: begin
                if (fire) begin
                    wr_en_d   = NUM_MEMS'(1) << seg_q;
                    wr_addr_d = addr_q;
                    wr_data_d = in_data;
                    addr_d    = addr_q + ADDR_W'(1);
                    rem_d     = rem_q - LEN_W'(1);
`ifdef CHECKSUM_EN
                    sum_d     = sum_q + in_data;
                    if (rem_q == LEN_W'(1)) state_d = S_CHK;
`else
                    if (rem_q == LEN_W'(1)) seg_end = 1'b1;
`endif
                end
            end
`ifdef CHECKSUM_EN
            S_CHK: begin
                if (fire) begin
                    if (in_data == sum_q) begin
                        seg_end = 1'b1;
                    end else begin
                        state_d    = S_ERR;
                        error_d    = 1'b1;
                        err_code_d = ERR_SUM;
                    end
                end
            end
`endif
            S_RUN: begin
                // Halt wins over saturation; the halt cycle itself is not counted
                if (cpu_halt) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_d == CNT_MAX) begin
                        state_d    = S_ERR;
                        error_d    = 1'b1;
                        err_code_d = ERR_TMO;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (seg_end) begin
            if (seg_q == LAST_SEG) begin
                state_d = S_RUN;
            end else begin
                seg_d   = seg_q + SEG_W'(1);
                state_d = S_HDR;
            end
        end

`ifdef CHECKSUM_EN
        in_ready_d = (state_d == S_HDR) || (state_d == S_DATA) || (state_d == S_CHK);
`else
        in_ready_d = (state_d == S_HDR) || (state_d == S_DATA);
`endif
        cpu_run_d  = (state_d == S_RUN);
    end

    always_ff @(posedge clk_CPU or posedge rst_CPU) begin
        if (rst_CPU) begin
            state_q    <= S_IDLE;
            seg_q      <= '0;
            rem_q      <= '0;
            addr_q     <= '0;
            in_ready_q <= 1'b0;
            wr_en_q    <= '0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            cpu_run_q  <= 1'b0;
            cnt_q      <= '0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            err_code_q <= '0;
`ifdef CHECKSUM_EN
            sum_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            seg_q      <= seg_d;
            rem_q      <= rem_d;
            addr_q     <= addr_d;
            in_ready_q <= in_ready_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            cpu_run_q  <= cpu_run_d;
            cnt_q      <= cnt_d;
            done_q     <= done_d;
            error_q    <= error_d;
            err_code_q <= err_code_d;
`ifdef CHECKSUM_EN
            sum_q      <= sum_d;
`endif
        end
    end

    assign in_ready  = in_ready_q;
    assign wr_en     = wr_en_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign cpu_run   = cpu_run_q;
    assign cycle_cnt = cnt_q;
    assign done      = done_q;
    assign error     = error_q;
    assign err_code  = err_code_q;

endmodule
